// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scanner.
// Holds digit geometry, the anode-off pattern, the slot-state encoding and
// the display payload (digit codes plus decimal points).
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned VALUE_W    = NUM_DIGITS * DIGIT_W;
    localparam int unsigned IDX_W      = 2;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_t;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    // One displayable frame: four hex digits plus per-digit decimal points.
    typedef struct packed {
        digits_t                digits;
        logic [NUM_DIGITS-1:0]  dp;
    } disp_t;

    // Active-low one-hot anode pattern for digit idx.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Host/display bundle for seg_scan_mux.
//   en, load, value, dp_in, blank_lz : control and data from the host
//   nibble, dp, an, frame_done       : registered display drive back out
interface seg_scan_mux_if;
    import seg_pkg::*;

    logic                  en;
    logic                  load;
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dp_in;
    logic                  blank_lz;
    logic [DIGIT_W-1:0]    nibble;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_done;

    modport master (
        output en, load, value, dp_in, blank_lz,
        input  nibble, dp, an, frame_done
    );

    modport slave (
        input  en, load, value, dp_in, blank_lz,
        output nibble, dp, an, frame_done
    );

endinterface

// File: rtl/seg_prescaler.sv
// Terminal-count slot prescaler: counts 0..PRESCALE-1 while en is high,
// wraps to 0 and flags the wrap cycle on tick_c.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable (counter frozen when low)
//   cnt      : current count (registered)
//   tick_c   : combinational, high in the cycle cnt wraps
module seg_prescaler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tick_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    assign tick_c = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed display scanner with anti-ghost blanking,
// frame-synchronous data update and optional leading-zero suppression.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg_scan_mux_if (en/load/value/dp_in/blank_lz in;
//              nibble/dp/an/frame_done out, all registered)
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave bus
);

    localparam int unsigned CNT_W     = $clog2(PRESCALE);
    localparam int unsigned G_LAST    = (GUARD == 0) ? 0 : GUARD - 1;
    localparam slot_state_t RST_STATE = (GUARD == 0) ? DRIVE : BLANK;

    logic [CNT_W-1:0]      cnt;
    logic                  tick_c;
    logic [IDX_W-1:0]      idx_q;
    slot_state_t           state_q, state_d;
    disp_t                 pend_q, act_q, in_c;
    logic                  pflag_q;
    logic                  boundary_c;
    logic [NUM_DIGITS-1:0] lz_c;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [DIGIT_W-1:0]    nibble_q, nibble_d;
    logic                  dp_q, dp_d;
    logic                  fd_q;

    seg_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .cnt    (cnt),
        .tick_c (tick_c)
    );

    assign in_c       = disp_t'({bus.value, bus.dp_in});
    assign boundary_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Digit k>=1 is suppressible when it and every digit above it are zero
    // and it carries no decimal point.
    always_comb begin
        zero_run = 1'b1;
        lz_c     = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (act_q.digits[k] == '0);
            lz_c[k]  = zero_run && !act_q.dp[k];
        end
    end

    // Slot FSM next state and next registered outputs.
    always_comb begin
        state_d  = state_q;
        an_d     = ANODE_OFF;
        nibble_d = act_q.digits[idx_q];
        dp_d     = act_q.dp[idx_q];

        case (state_q)
            BLANK: if (bus.en && (cnt == CNT_W'(G_LAST))) state_d = DRIVE;
            DRIVE: if (tick_c && (GUARD != 0))            state_d = BLANK;
            default:                                      state_d = RST_STATE;
        endcase

        if (bus.en && (state_q == DRIVE) && !(bus.blank_lz && lz_c[idx_q])) begin
            an_d = anode_sel(idx_q);
        end
    end

    // Slot state, digit index and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            idx_q    <= '0;
            an_q     <= ANODE_OFF;
            nibble_q <= '0;
            dp_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (tick_c) idx_q <= idx_q + IDX_W'(1);
            an_q     <= an_d;
            nibble_q <= nibble_d;
            dp_q     <= dp_d;
            fd_q     <= boundary_c;
        end
    end

    // Pending/active data: active only moves at the frame wrap; a load landing
    // on the wrap cycle goes straight to active.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            act_q   <= '0;
            pflag_q <= 1'b0;
        end else if (boundary_c) begin
            if (bus.load)     act_q <= in_c;
            else if (pflag_q) act_q <= pend_q;
            pflag_q <= 1'b0;
        end else if (bus.load) begin
            pend_q  <= in_c;
            pflag_q <= 1'b1;
        end
    end

    assign bus.an         = an_q;
    assign bus.nibble     = nibble_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux at PRESCALE=4, GUARD=1.
module tb_seg_scan_mux;

    localparam int P     = 4;
    localparam int G     = 1;
    localparam int FRAME = 4 * P;

    typedef logic [9:0] exp_t; // {an, nibble, dp, frame_done}

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    seg_scan_mux_if bus();

    seg_scan_mux #(.PRESCALE(P), .GUARD(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one frame-position counter over enabled cycles.
    exp_t        sb_q[$];
    int          m_ph;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pflag;

    always @(posedge clk) begin : model
        int         dig, sub;
        logic [3:0] an, nib;
        logic       d, bnd, sup;
        if (rst) begin
            m_ph = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pflag = 1'b0;
            sb_q.push_back({4'hF, 4'h0, 1'b0, 1'b0});
        end else begin
            dig = m_ph / P;
            sub = m_ph % P;
            nib = 4'(m_act >> (4 * dig));
            d   = m_adp[dig];
            sup = bus.blank_lz && (dig >= 1) && ((m_act >> (4 * dig)) == 16'h0) && !m_adp[dig];
            an  = (bus.en && (sub >= G) && !sup) ? ~(4'b0001 << dig) : 4'hF;
            bnd = bus.en && (m_ph == FRAME - 1);
            sb_q.push_back({an, nib, d, bnd});
            if (bnd) begin
                if (bus.load) begin
                    m_act = bus.value; m_adp = bus.dp_in;
                end else if (m_pflag) begin
                    m_act = m_pend; m_adp = m_pdp;
                end
                m_pflag = 1'b0;
                m_ph    = 0;
            end else begin
                if (bus.load) begin
                    m_pend = bus.value; m_pdp = bus.dp_in; m_pflag = 1'b1;
                end
                if (bus.en) m_ph++;
            end
        end
    end

    // Pop expected output for every clocked cycle and compare.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out", {22'h0, bus.an, bus.nibble, bus.dp, bus.frame_done}, {22'h0, e});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        bus.value = v; bus.dp_in = d; bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd(output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step(1);
            waited++;
            if (bus.frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("fd_wait", 32'(found), 32'd1);
    endtask

    initial begin
        int w, pulses;
        rst = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
        step(3);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_nib", 32'(bus.nibble), 32'h0);
        check("rst_dp", 32'(bus.dp), 32'h0);
        check("rst_fd", 32'(bus.frame_done), 32'h0);
        rst = 1'b0;
        step(1);
        check("rst1_an", 32'(bus.an), 32'hF);
        check("rst1_nib", 32'(bus.nibble), 32'h0);

        // Basic scan of 1234.
        bus.en = 1'b1;
        load_val(16'h1234, 4'h0);
        step(40);

        // Leading-zero blanking on and off, then a dp keeping digit 2 lit.
        bus.blank_lz = 1'b1;
        load_val(16'h00A5, 4'h0);
        step(40);
        bus.blank_lz = 1'b0;
        step(20);
        bus.blank_lz = 1'b1;
        load_val(16'h00A5, 4'b0100);
        step(40);
        bus.blank_lz = 1'b0;

        // Two loads in one frame: last wins, visible only from next frame.
        wait_fd(w);
        step(5);
        load_val(16'hBEEF, 4'h1);
        step(3);
        load_val(16'hCAFE, 4'h8);
        step(40);

        // Load on the wrap cycle appears in the frame that starts right then.
        wait_fd(w);
        step(FRAME - 1);
        load_val(16'h5678, 4'h0);
        step(2);
        check("bypass_an", 32'(bus.an), 32'hE);
        check("bypass_nib", 32'(bus.nibble), 32'h8);

        // Ten frames -> ten pulses, sixteen cycles apart.
        wait_fd(w);
        pulses = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            step(1);
            if (bus.frame_done) pulses++;
        end
        check("fd_count", 32'(pulses), 32'd10);
        check("fd_last", 32'(bus.frame_done), 32'd1);
        wait_fd(w);
        check("fd_spacing", 32'(w), 32'(FRAME));

        // en low for 7 cycles mid-slot stretches the frame to 23 cycles.
        step(6);
        bus.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("en_low_an", 32'(bus.an), 32'hF);
        end
        bus.en = 1'b1;
        wait_fd(w);
        check("fd_stretch", 32'(6 + 7 + w), 32'd23);

        // Reset in the middle of digit 2's drive window.
        step(10);
        check("pre_rst_an", 32'(bus.an), 32'hB);
        check("pre_rst_nib", 32'(bus.nibble), 32'h6);
        rst = 1'b1;
        step(1);
        check("mid_rst_an", 32'(bus.an), 32'hF);
        check("mid_rst_nib", 32'(bus.nibble), 32'h0);
        check("mid_rst_fd", 32'(bus.frame_done), 32'h0);
        rst = 1'b0;
        step(2);
        check("post_rst_an", 32'(bus.an), 32'hE);
        check("post_rst_nib", 32'(bus.nibble), 32'h0);
        step(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter PRESCALE, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter GUARD, default 2, anti-ghost blank cycles at slot start; legal 0..PRESCALE-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  scan enable; low = anodes off, counters frozen.
REQ-006 load  input  1  one-cycle strobe capturing value/dp_in.
REQ-007 value  input  16  four hex digits; digit k = value[4k+3:4k].
REQ-008 dp_in  input  4  decimal point per digit, active-high.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 nibble  output  4  current digit code, feeds downstream 4-bit to 7-segment decoder.
REQ-011 dp  output  1  decimal point for current digit.
REQ-012 an  output  4  digit anodes, active-low, one-hot-low when driving.
REQ-013 frame_done  output  1  one-cycle pulse on frame wrap.

Function
REQ-014 Two data registers: pending (captured on load) and active (displayed); active SHALL change only at a frame boundary.
REQ-015 Frame boundary = cycle where digit index wraps 3->0; active<=pending at that edge if a load occurred since the previous boundary.
REQ-016 load coincident with boundary cycle SHALL bypass: value/dp_in go directly to active at that edge.
REQ-017 Multiple loads within one frame: last one wins.
REQ-018 Prescaler counts 0..PRESCALE-1 while en high; at PRESCALE-1 it wraps to 0 and digit index increments 0->1->2->3->0.
REQ-019 Slot FSM states: BLANK (prescaler < GUARD) and DRIVE (prescaler >= GUARD); GUARD=0 means BLANK never entered.
REQ-020 In BLANK, an=4'b1111; nibble/dp already hold new digit's values.
REQ-021 In DRIVE, an[idx]=0, other bits 1; nibble=active[4idx+3:4idx]; dp=active_dp[idx].
REQ-022 Outputs registered: an/nibble/dp reflect state with one cycle latency from prescaler/index.
REQ-023 Leading-zero blanking: when blank_lz high, digit k (k>=1) SHALL be suppressed (anode held 1) if active digits k..3 are all zero and active_dp[k] is 0; digit 0 never suppressed.
REQ-024 frame_done SHALL pulse high exactly one cycle per frame, in the cycle after the 3->0 wrap edge; never while en low.
REQ-025 en low: an=4'b1111, prescaler/index/FSM frozen, load still captured to pending; scanning resumes from frozen point when en returns high.
REQ-026 Frame period = 4*PRESCALE enabled cycles exactly; no counter width overflow for any legal PRESCALE.

Reset
REQ-027 While rst high: prescaler=0, idx=0, FSM=BLANK (DRIVE if GUARD=0), pending=active=0, dp regs=0, load-flag=0.
REQ-028 Outputs during and one cycle after reset: an=4'b1111, nibble=4'h0, dp=0, frame_done=0.
REQ-029 rst SHALL dominate load and en; reset mid-frame discards pending and active data.

Structure
REQ-030 Shared package seg_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4, ANODE_OFF=4'b1111 and the slot-state enumeration {BLANK, DRIVE}.
REQ-031 One sub-module, seg_prescaler (terminal-count counter with enable and sync reset), SHALL provide the slot tick; digit indexing, FSM and data registers stay in seg_scan_mux.
REQ-032 nibble SHALL connect directly to the existing 4-bit-to-7-segment decoder with no extra logic.

Verification (PRESCALE=4, GUARD=1)
REQ-033 Reset then en=1, load value=16'h1234 -> after first boundary, DRIVE slots show an=1110/nibble 4, 1101/3, 1011/2, 0111/1; each DRIVE lasts 3 cycles preceded by 1 cycle an=1111.
REQ-034 Load 16'h00A5 with blank_lz=1 -> digits 2,3 keep an=1111 in DRIVE; digits 0,1 show 5,A; with blank_lz=0 digits 2,3 show 0.
REQ-035 Load 16'hBEEF mid-frame, then 16'hCAFE same frame -> current frame unchanged, next frame shows CAFE; load on boundary cycle shows new value in the immediately starting frame.
REQ-036 frame_done counted over 10 frames -> exactly 10 pulses, spacing 16 cycles; en dropped for 7 cycles mid-slot -> an=1111 throughout, spacing 23 cycles for that frame.
REQ-037 rst asserted mid-DRIVE of digit 2 -> next cycle an=1111, nibble=0, frame_done=0; after release scan restarts at digit 0 showing 0.
